// File: rtl/fir_tap_filter_if.sv
// Tap-stream, sample and result signals of fir_tap_filter.
// The master side drives coefficients and samples. The slave side is the filter.
interface fir_tap_filter_if #(
    parameter int COEFF_W  = 16,
    parameter int SAMPLE_W = 16
);
    logic [COEFF_W-1:0]  tapcoeff;
    logic [7:0]          tapnum;
    logic                tap_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] filt_out;
    logic                filt_valid;
    logic                coeff_loaded;

    modport master (
        output tapcoeff, tapnum, tap_valid, sample_in, sample_valid,
        input  sample_ready, filt_out, filt_valid, coeff_loaded
    );

    modport slave (
        input  tapcoeff, tapnum, tap_valid, sample_in, sample_valid,
        output sample_ready, filt_out, filt_valid, coeff_loaded
    );
endinterface

// File: rtl/fir_tap_filter.sv
// Sequential MAC FIR filter: one tap per clock over a NTAPS-deep delay line.
// Coefficients arrive serially into a shadow bank and are copied to the active bank on each sample accept.
module fir_tap_filter #(
    parameter int NTAPS    = 4,
    parameter int COEFF_W  = 16,
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 40
) (
    input  logic            clk,
    input  logic            reset,
    fir_tap_filter_if.slave bus
);
    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = COEFF_W + SAMPLE_W;
    localparam int SH = COEFF_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [COEFF_W-1:0]  shadow_q [NTAPS];
    logic [COEFF_W-1:0]  shadow_d [NTAPS];
    logic [COEFF_W-1:0]  active_q [NTAPS];
    logic [COEFF_W-1:0]  active_d [NTAPS];
    logic [SAMPLE_W-1:0] x_q [NTAPS];
    logic [SAMPLE_W-1:0] x_d [NTAPS];
    logic [NTAPS-1:0]    mask_q, mask_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [KW-1:0]       k_q, k_d;
    logic [SAMPLE_W-1:0] filt_out_q, filt_out_d;
    logic                filt_valid_q, filt_valid_d;

    logic                loaded, ready, accept, tap_hit;
    logic signed [PW-1:0]    a_ext, x_ext, prod;
    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-SAMPLE_W:0] upper;
    logic [SAMPLE_W-1:0]     sat;

    assign loaded           = &mask_q;
    assign ready            = (state_q == S_IDLE) && loaded;
    assign bus.sample_ready = ready;
    assign bus.coeff_loaded = loaded;
    assign bus.filt_out     = filt_out_q;
    assign bus.filt_valid   = filt_valid_q;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        x_d          = x_q;
        mask_d       = mask_q;
        acc_d        = acc_q;
        k_d          = k_q;
        filt_out_d   = filt_out_q;
        filt_valid_d = 1'b0;

        accept  = ready && bus.sample_valid;
        tap_hit = bus.tap_valid && ({1'b0, bus.tapnum} < 9'(NTAPS));

        a_ext = {{SAMPLE_W{active_q[k_q][COEFF_W-1]}}, active_q[k_q]};
        x_ext = {{COEFF_W{x_q[k_q][SAMPLE_W-1]}}, x_q[k_q]};
        prod  = a_ext * x_ext;

        // Clamp when the bits above the output sign are not a pure sign extension.
        shifted = acc_q >>> SH;
        upper   = shifted[ACC_W-1:SAMPLE_W-1];
        if ((&upper) || !(|upper))
            sat = shifted[SAMPLE_W-1:0];
        else if (shifted[ACC_W-1])
            sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            sat = {1'b0, {(SAMPLE_W-1){1'b1}}};

        if (tap_hit) begin
            shadow_d[bus.tapnum[KW-1:0]] = bus.tapcoeff;
            mask_d[bus.tapnum[KW-1:0]]   = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // shadow_q is the pre-edge bank, so a same-edge write waits for the next sample
                    x_d[0] = bus.sample_in;
                    for (int unsigned i = 1; i < NTAPS; i++)
                        x_d[i] = x_q[i-1];
                    for (int unsigned i = 0; i < NTAPS; i++)
                        active_d[i] = shadow_q[i];
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NTAPS-1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                filt_out_d   = sat;
                filt_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            acc_q        <= '0;
            k_q          <= '0;
            filt_out_q   <= '0;
            filt_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
                x_q[i]      <= '0;
            end
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            acc_q        <= acc_d;
            k_q          <= k_d;
            filt_out_q   <= filt_out_d;
            filt_valid_q <= filt_valid_d;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
                x_q[i]      <= x_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_filter.sv
// Scoreboard bench for fir_tap_filter: the stimulus queues hand-computed results and the monitor checks them.
module tb_fir_tap_filter;
    logic clk = 1'b0;
    logic reset = 1'b0;

    fir_tap_filter_if #(.COEFF_W(16), .SAMPLE_W(16)) bus();

    fir_tap_filter #(.NTAPS(4), .COEFF_W(16), .SAMPLE_W(16), .ACC_W(40)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    int          edge_q[$];
    logic        prev_fv = 1'b0;
    logic [15:0] mon_e;
    int          mon_ed;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every filt_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (bus.filt_valid === 1'b1) begin
            chk("fv_single_cycle", 32'(prev_fv), 32'd0);
            chk("ready_in_valid_cycle", 32'(bus.sample_ready), 32'd1);
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(bus.filt_valid), 32'd0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ed = edge_q.pop_front();
                chk("filt_out", 32'(bus.filt_out), 32'(mon_e));
                chk("result_edge", 32'(cyc), 32'(mon_ed));
            end
        end
        prev_fv = bus.filt_valid;
    end

    task automatic write_tap(input logic [7:0] tn, input logic [15:0] tc);
        bus.tap_valid = 1'b1;
        bus.tapnum    = tn;
        bus.tapcoeff  = tc;
        @(posedge clk);
        #1;
        bus.tap_valid = 1'b0;
    endtask

    task automatic load_taps(input logic [15:0] c0, c1, c2, c3);
        write_tap(8'd0, c0);
        write_tap(8'd1, c1);
        write_tap(8'd2, c2);
        write_tap(8'd3, c3);
    endtask

    // Optionally writes a tap on the very edge the sample is accepted.
    task automatic send(input logic [15:0] s, input logic [15:0] e,
                        input bit wr, input logic [7:0] tn, input logic [15:0] tc);
        bit got;
        got = 1'b0;
        bus.sample_in    = s;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.sample_ready === 1'b1) begin
                if (wr) begin
                    bus.tap_valid = 1'b1;
                    bus.tapnum    = tn;
                    bus.tapcoeff  = tc;
                end
                exp_q.push_back(e);
                edge_q.push_back(cyc + 6);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.tap_valid    = 1'b0;
    endtask

    task automatic drain(input logic [15:0] last);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("filt_out_hold", 32'(bus.filt_out), 32'(last));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        logic [15:0] b2b_exp [4];
        b2b_exp = '{16'h0600, 16'h0300, 16'h0100, 16'h0000};

        bus.tapcoeff     = '0;
        bus.tapnum       = '0;
        bus.tap_valid    = 1'b0;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_filt_out", 32'(bus.filt_out), 32'd0);
        chk("rst_filt_valid", 32'(bus.filt_valid), 32'd0);
        chk("rst_sample_ready", 32'(bus.sample_ready), 32'd0);
        chk("rst_coeff_loaded", 32'(bus.coeff_loaded), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Partial load plus an out-of-range index must not enable the filter.
        write_tap(8'd0, 16'h4000);
        write_tap(8'd1, 16'h2000);
        write_tap(8'd2, 16'h1000);
        write_tap(8'd8, 16'h7FFF);
        bus.sample_in    = 16'h1000;
        bus.sample_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("nl_coeff_loaded", 32'(bus.coeff_loaded), 32'd0);
            chk("nl_sample_ready", 32'(bus.sample_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        write_tap(8'd3, 16'h0800);
        chk("tap3_coeff_loaded", 32'(bus.coeff_loaded), 32'd1);
        chk("tap3_sample_ready", 32'(bus.sample_ready), 32'd1);

        // Impulse response.
        send(16'h1000, 16'h0800, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0400, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0200, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0100, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0000, 1'b0, 8'd0, 16'h0);
        drain(16'h0000);

        // Tap 0 rewritten during MAC: current sample still uses 0x4000.
        send(16'h1000, 16'h0800, 1'b0, 8'd0, 16'h0);
        write_tap(8'd0, 16'h2000);
        send(16'h0000, 16'h0400, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0200, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0100, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0000, 1'b0, 8'd0, 16'h0);
        send(16'h1000, 16'h0400, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0400, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0200, 1'b0, 8'd0, 16'h0);
        send(16'h0000, 16'h0100, 1'b0, 8'd0, 16'h0);
        // Write on the accept edge applies only to the following sample.
        send(16'h1000, 16'h0400, 1'b1, 8'd0, 16'h4000);
        send(16'h1000, 16'h0C00, 1'b0, 8'd0, 16'h0);
        drain(16'h0C00);

        // Back-to-back with sample_valid held high; delay line is [1000,1000,0,0].
        bus.sample_in    = 16'h0000;
        bus.sample_valid = 1'b1;
        last_acc = 0;
        for (int j = 0; j < 4; j++) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.sample_ready === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) chk("b2b_accept_timeout", 32'(got), 32'd1);
            exp_q.push_back(b2b_exp[j]);
            edge_q.push_back(cyc + 6);
            if (j > 0) chk("b2b_accept_gap", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            @(posedge clk);
        end
        #1;
        bus.sample_valid = 1'b0;
        drain(16'h0000);

        // Saturation.
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        load_taps(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send(16'h7FFF, 16'h7FFE, 1'b0, 8'd0, 16'h0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 8'd0, 16'h0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 8'd0, 16'h0);
        send(16'h7FFF, 16'h7FFF, 1'b0, 8'd0, 16'h0);
        send(16'h8000, 16'h7FFF, 1'b0, 8'd0, 16'h0);
        send(16'h8000, 16'hFFFE, 1'b0, 8'd0, 16'h0);
        send(16'h8000, 16'h8000, 1'b0, 8'd0, 16'h0);
        send(16'h8000, 16'h8000, 1'b0, 8'd0, 16'h0);
        drain(16'h8000);

        // Asynchronous reset at k=2 aborts the result.
        send(16'h1000, 16'h0000, 1'b0, 8'd0, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_filt_out", 32'(bus.filt_out), 32'd0);
        chk("abort_filt_valid", 32'(bus.filt_valid), 32'd0);
        chk("abort_coeff_loaded", 32'(bus.coeff_loaded), 32'd0);
        chk("abort_sample_ready", 32'(bus.sample_ready), 32'd0);
        exp_q.delete();
        edge_q.delete();
        @(negedge clk) reset = 1'b1;
        bus.sample_in    = 16'h1000;
        bus.sample_valid = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_ready", 32'(bus.sample_ready), 32'd0);
        end
        chk("post_abort_filt_out", 32'(bus.filt_out), 32'd0);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        load_taps(16'h4000, 16'h2000, 16'h1000, 16'h0800);
        send(16'h1000, 16'h0800, 1'b0, 8'd0, 16'h0);
        drain(16'h0800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
